// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: opcodes, FSM states, op classification.
// Define ALU_DIV_EN to compile in the iterative DIVU datapath.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {INACTIVO, CALCULO, FIN} estado_t;

  // Without the divider, DIVU is treated like any other undefined single-cycle opcode.
  function automatic logic es_iterativa(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MULTU) || (op == OP_DIVU);
`else
    return (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// The DIVU path is present only when ALU_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             activo,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ultimo
);

  logic [SHW-1:0]   contador;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operando;
  logic             es_div;
  logic [WIDTH:0]   suma;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   parcial;
  logic [WIDTH:0]   resta;
`endif

  assign ultimo = (contador == '0);

  // hi/lo present the accumulator value after the iteration taken on the coming edge.
  always_comb begin
    hi   = acc_hi;
    lo   = acc_lo;
    suma = '0;
`ifdef ALU_DIV_EN
    parcial = '0;
    resta   = '0;
`endif
    if (es_div) begin
`ifdef ALU_DIV_EN
      // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
      parcial = {acc_hi, acc_lo[WIDTH-1]};
      resta   = parcial - {1'b0, operando};
      if (!resta[WIDTH]) begin
        hi = resta[WIDTH-1:0];
        lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi = parcial[WIDTH-1:0];
        lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
`endif
    end else begin
      suma = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operando} : '0);
      hi   = suma[WIDTH:1];
      lo   = {suma[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operando <= '0;
      es_div   <= 1'b0;
    end else if (start) begin
      contador <= SHW'(WIDTH - 1);
      acc_hi   <= '0;
      acc_lo   <= a;
      operando <= b;
      es_div   <= es_iterativa(op) && (op == OP_DIVU);
    end else if (activo) begin
      acc_hi <= hi;
      acc_lo <= lo;
      if (contador != '0)
        contador <= contador - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU into HI/LO.
// Define ALU_DIV_EN to enable DIVU; otherwise opcode 1010 behaves as undefined.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic [WIDTH-1:0] entrada_a,
  input  logic [WIDTH-1:0] entrada_b,
  input  logic [3:0]       control_alu,
  output logic [WIDTH-1:0] resultado,
  output logic             cero,
  output logic             desbordamiento,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ocupado,
  output logic             listo
);

  estado_t          estado, estado_sig;
  logic             acepta;
  logic             iterativa;
  logic [WIDTH-1:0] res_comb;
  logic             ovf_comb;
  logic [WIDTH-1:0] suma;
  logic [WIDTH-1:0] resta;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic             it_ultimo;

  assign acepta    = inicio && (estado != CALCULO);
  assign iterativa = es_iterativa(control_alu);
  assign ocupado   = (estado == CALCULO);
  assign cero      = (resultado == '0);
  assign suma      = entrada_a + entrada_b;
  assign resta     = entrada_a - entrada_b;

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (acepta && iterativa),
    .activo (estado == CALCULO),
    .op     (control_alu),
    .a      (entrada_a),
    .b      (entrada_b),
    .hi     (it_hi),
    .lo     (it_lo),
    .ultimo (it_ultimo)
  );

  // Single-cycle datapath; iterative and undefined opcodes fall through to zero.
  always_comb begin
    res_comb = '0;
    ovf_comb = 1'b0;
    case (control_alu)
      OP_AND:  res_comb = entrada_a & entrada_b;
      OP_OR:   res_comb = entrada_a | entrada_b;
      OP_ADD: begin
        res_comb = suma;
        ovf_comb = (entrada_a[WIDTH-1] == entrada_b[WIDTH-1]) &&
                   (suma[WIDTH-1] != entrada_a[WIDTH-1]);
      end
      OP_XOR:  res_comb = entrada_a ^ entrada_b;
      OP_SLL:  res_comb = entrada_a << entrada_b[SHW-1:0];
      OP_SRL:  res_comb = entrada_a >> entrada_b[SHW-1:0];
      OP_SUB: begin
        res_comb = resta;
        ovf_comb = (entrada_a[WIDTH-1] != entrada_b[WIDTH-1]) &&
                   (resta[WIDTH-1] != entrada_a[WIDTH-1]);
      end
      OP_SLT:  res_comb = {{(WIDTH-1){1'b0}}, $signed(entrada_a) < $signed(entrada_b)};
      OP_SLTU: res_comb = {{(WIDTH-1){1'b0}}, entrada_a < entrada_b};
      OP_NOR:  res_comb = ~(entrada_a | entrada_b);
      default: res_comb = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      estado <= INACTIVO;
    else
      estado <= estado_sig;
  end

  // FIN accepts a new request exactly like INACTIVO.
  always_comb begin
    estado_sig = estado;
    case (estado)
      INACTIVO, FIN: estado_sig = (acepta && iterativa) ? CALCULO : INACTIVO;
      CALCULO:       if (it_ultimo) estado_sig = FIN;
      default:       estado_sig = INACTIVO;
    endcase
  end

  // hi/lo only change on the final iteration, so a partial product is never visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultado      <= '0;
      desbordamiento <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      listo          <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (estado == CALCULO) begin
        if (it_ultimo) begin
          hi             <= it_hi;
          lo             <= it_lo;
          resultado      <= it_lo;
          desbordamiento <= 1'b0;
          listo          <= 1'b1;
        end
      end else if (acepta && !iterativa) begin
        resultado      <= res_comb;
        desbordamiento <= ovf_comb;
        listo          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo at WIDTH=32.
// DIVU expectations follow whether ALU_DIV_EN is defined for the build.
module tb_alu_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [31:0] entrada_a;
  logic [31:0] entrada_b;
  logic [3:0]  control_alu;
  logic [31:0] resultado;
  logic        cero;
  logic        desbordamiento;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ocupado;
  logic        listo;

  int errors = 0;
  int checks = 0;

  alu_multiciclo #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .inicio         (inicio),
    .entrada_a      (entrada_a),
    .entrada_b      (entrada_b),
    .control_alu    (control_alu),
    .resultado      (resultado),
    .cero           (cero),
    .desbordamiento (desbordamiento),
    .hi             (hi),
    .lo             (lo),
    .ocupado        (ocupado),
    .listo          (listo)
  );

  always #5 clk = ~clk;

  // Presents a request mid-cycle and returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    control_alu = op;
    entrada_a   = a;
    entrada_b   = b;
    inicio      = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Counts edges until listo rises, bounded so a stuck DUT still reaches the summary.
  task automatic waitListo(output int ciclos);
    ciclos = 0;
    while (!listo && ciclos < 100) begin
      @(posedge clk);
      #1;
      ciclos++;
    end
  endtask

  int ciclos;
  int busy_cycles;
  int listo_early;

  initial begin
    $display("[TB] start");
    reset       = 1'b1;
    inicio      = 1'b0;
    entrada_a   = '0;
    entrada_b   = '0;
    control_alu = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_res", resultado, 32'h0);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_cero", 32'(cero), 32'd1);
    checkOutput("reset_listo", 32'(listo), 32'd0);
    checkOutput("reset_ocupado", 32'(ocupado), 32'd0);
    checkOutput("reset_ovf", 32'(desbordamiento), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    checkOutput("add_res", resultado, 32'h8000_0000);
    checkOutput("add_ovf", 32'(desbordamiento), 32'd1);
    checkOutput("add_listo", 32'(listo), 32'd1);
    checkOutput("add_ocupado", 32'(ocupado), 32'd0);
    checkOutput("add_cero", 32'(cero), 32'd0);

    applyStimulus(4'b0110, 32'd5, 32'd5);
    checkOutput("sub_res", resultado, 32'h0);
    checkOutput("sub_cero", 32'(cero), 32'd1);
    checkOutput("sub_ovf", 32'(desbordamiento), 32'd0);
    checkOutput("b2b_listo", 32'(listo), 32'd1);

    applyStimulus(4'b0110, 32'h8000_0000, 32'h0000_0001);
    checkOutput("subovf_res", resultado, 32'h7FFF_FFFF);
    checkOutput("subovf_ovf", 32'(desbordamiento), 32'd1);

    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("slt_res", resultado, 32'd1);
    applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("sltu_res", resultado, 32'd0);
    applyStimulus(4'b0100, 32'h0000_0001, 32'h0000_0021);
    checkOutput("sll_res", resultado, 32'd2);
    applyStimulus(4'b0101, 32'h8000_0000, 32'h0000_001F);
    checkOutput("srl_res", resultado, 32'd1);
    applyStimulus(4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0);
    checkOutput("xor_res", resultado, 32'hF0F0_F0F0);
    applyStimulus(4'b1100, 32'h0F0F_0F0F, 32'hF0F0_F000);
    checkOutput("nor_res", resultado, 32'h0000_00F0);
    applyStimulus(4'b0001, 32'h0000_1200, 32'h0000_0034);
    checkOutput("or_res", resultado, 32'h0000_1234);
    applyStimulus(4'b1111, 32'h1234_5678, 32'h1111_1111);
    checkOutput("undef_res", resultado, 32'h0);
    checkOutput("undef_listo", 32'(listo), 32'd1);

    @(posedge clk);
    #1;
    checkOutput("listo_falls", 32'(listo), 32'd0);

    // MULTU with an AND request pulsed part-way through the iterations.
    applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cycles = ocupado ? 1 : 0;
    listo_early = listo ? 1 : 0;
    for (int j = 1; j < 32; j++) begin
      @(posedge clk);
      #1;
      if (ocupado) busy_cycles++;
      if (listo) listo_early++;
      if (j == 10) begin
        control_alu = 4'b0000;
        entrada_a   = 32'h0000_00F0;
        entrada_b   = 32'h0000_003C;
        inicio      = 1'b1;
      end
      if (j == 11) inicio = 1'b0;
      if (j == 5) checkOutput("mul_hi_hold", hi, 32'h0);
    end
    checkOutput("mul_busy_cycles", busy_cycles, 32'd32);
    checkOutput("mul_listo_early", listo_early, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mul_listo", 32'(listo), 32'd1);
    checkOutput("mul_ocupado", 32'(ocupado), 32'd0);
    checkOutput("mul_hi", hi, 32'hFFFF_FFFE);
    checkOutput("mul_lo", lo, 32'h0000_0001);
    checkOutput("mul_res", resultado, 32'h0000_0001);
    checkOutput("mul_ovf", 32'(desbordamiento), 32'd0);

    applyStimulus(4'b0000, 32'h0000_00F0, 32'h0000_003C);
    checkOutput("fin_and_res", resultado, 32'h0000_0030);
    checkOutput("fin_and_listo", 32'(listo), 32'd1);
    checkOutput("fin_and_hi", hi, 32'hFFFF_FFFE);
    checkOutput("fin_and_lo", lo, 32'h0000_0001);

`ifdef ALU_DIV_EN
    applyStimulus(4'b1010, 32'd100, 32'd7);
    waitListo(ciclos);
    checkOutput("div_latency", ciclos, 32'd32);
    checkOutput("div_lo", lo, 32'd14);
    checkOutput("div_hi", hi, 32'd2);
    checkOutput("div_res", resultado, 32'd14);
    applyStimulus(4'b1010, 32'd9, 32'd0);
    waitListo(ciclos);
    checkOutput("div0_latency", ciclos, 32'd32);
    checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
    checkOutput("div0_hi", hi, 32'd9);
`else
    applyStimulus(4'b1010, 32'd100, 32'd7);
    checkOutput("nodiv_res", resultado, 32'h0);
    checkOutput("nodiv_listo", 32'(listo), 32'd1);
    checkOutput("nodiv_ocupado", 32'(ocupado), 32'd0);
    checkOutput("nodiv_hi", hi, 32'hFFFF_FFFE);
    checkOutput("nodiv_lo", lo, 32'h0000_0001);
`endif

    // Asynchronous reset at iteration 10 discards the partial product.
    applyStimulus(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_res", resultado, 32'h0);
    checkOutput("rst_mid_hi", hi, 32'h0);
    checkOutput("rst_mid_lo", lo, 32'h0);
    checkOutput("rst_mid_cero", 32'(cero), 32'd1);
    checkOutput("rst_mid_ocupado", 32'(ocupado), 32'd0);
    checkOutput("rst_mid_listo", 32'(listo), 32'd0);
    checkOutput("rst_mid_ovf", 32'(desbordamiento), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(4'b1001, 32'd3, 32'd4);
    waitListo(ciclos);
    checkOutput("mul34_latency", ciclos, 32'd32);
    checkOutput("mul34_lo", lo, 32'd12);
    checkOutput("mul34_hi", hi, 32'd0);
    checkOutput("mul34_res", resultado, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised successor to the single-cycle datapath ALU for the MIPS core. It keeps the existing 4-bit operation encoding and adds XOR, shifts, signed and unsigned set-less-than, and signed overflow. It also adds iterative unsigned multiply and divide into HI/LO registers, with a start/busy/done handshake. It sits in the EX stage, and the control unit stalls on `ocupado`.

## Interface
- `WIDTH`, default 32: data width; power of two, ≥ 4.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inicio` in 1: start request; operands and op sampled on the edge where it is high and the block is idle.
- `entrada_a` in WIDTH: operand A, or the dividend.
- `entrada_b` in WIDTH: operand B, the divisor, or the shift amount (low SHW bits).
- `control_alu` in 4: operation code.
- `resultado` out WIDTH: registered result.
- `cero` out 1: high when `resultado` == 0; combinational from the registered `resultado`.
- `desbordamiento` out 1: registered signed overflow for ADD/SUB; 0 for all other operations.
- `hi`, `lo` out WIDTH each: multiply/divide result registers.
- `ocupado` out 1: iterative operation in progress; `inicio` is ignored while this is high.
- `listo` out 1: one-cycle pulse; `resultado`, `hi`, `lo` and `desbordamiento` are valid.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 MULTU, 1010 DIVU, 1100 NOR.
- Any other opcode gives `resultado` = 0 and completes as a single-cycle operation.
- Single-cycle operations are computed combinationally and registered on the accepting edge. `hi` and `lo` are unchanged.
- Shifts use `entrada_b[SHW-1:0]` only.
- SLT and SLTU return 1 or 0, zero-extended.
- Overflow for ADD: the operands have the same sign and the sum sign differs. For SUB: the operands have different signs and the result sign differs from A. The arithmetic result is still written.
- MULTU: shift-add, one bit per cycle. The 2·WIDTH product goes to {`hi`,`lo`}; `resultado` = `lo`.
- DIVU: restoring division, one bit per cycle. `lo` = quotient, `hi` = remainder, `resultado` = quotient.
- Divide by zero: `lo` = all ones, `hi` = `entrada_a`, same latency as a normal divide.
- FSM states, from the package:
  - INACTIVO: accepts `inicio`. A single-cycle op stays in INACTIVO; MULTU/DIVU go to CALCULO with the counter at WIDTH-1.
  - CALCULO: one iteration per edge. When the counter reaches 0, the next state is FIN.
  - FIN: `listo` = 1 and `ocupado` = 0; `inicio` is accepted exactly as in INACTIVO.
- `hi` and `lo` update only at the end of MULTU/DIVU, never mid-iteration.
- Reset, including mid-operation: state INACTIVO, counter 0; `resultado`, `hi`, `lo`, `desbordamiento`, `listo` and `ocupado` are 0; `cero` = 1. A partial result is discarded.

## Timing
- Single-cycle op accepted at edge k: results and `listo` = 1 during cycle k+1; `ocupado` stays 0.
- Back-to-back single-cycle ops are accepted every cycle, so `listo` stays high.
- MULTU/DIVU accepted at edge k: `ocupado` = 1 from edge k to edge k+WIDTH. Results and `listo` = 1 during cycle k+WIDTH, so latency is WIDTH cycles.
- `listo` falls after one cycle unless a new single-cycle op is accepted in FIN.
- `inicio` while `ocupado` = 1 has no effect; operand and opcode changes during CALCULO have no effect.
- `cero` follows `resultado` in the same cycle. Its value before the first `listo` is that of the reset value.

## Configuration
- `ALU_DIV_EN`, defined: the DIVU datapath (restoring divider, remainder register) is compiled in.
- `ALU_DIV_EN`, undefined: opcode 1010 is treated as an undefined opcode (`resultado` = 0, single-cycle, `hi`/`lo` unchanged). MULTU is unaffected.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`OP_AND` … `OP_NOR`);
  - FSM state typedef `estado_t` {INACTIVO, CALCULO, FIN};
  - a function returning whether an opcode is iterative (honours `ALU_DIV_EN`).
- Sub-module `alu_muldiv_iter`: holds the iteration counter, partial-product/remainder registers and the shift-add/restore datapath.
  - Interface: start, op, a, b, WIDTH; outputs `hi`/`lo` and last-iteration.
  - The top level holds the FSM, the single-cycle logic and the output registers.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 1 → `resultado` 0x80000000, `desbordamiento` 1, `listo` next cycle. SUB 5−5 → `resultado` 0, `cero` 1.
- SLT with A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. SLL of 1 by B=0x21 → 2 (only the low 5 bits are used).
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` 0xFFFFFFFE, `lo` 0x00000001. `listo` arrives exactly 32 cycles after the accepting edge, and `ocupado` is high for those 32 cycles.
- DIVU 100 / 7 → `lo` 14, `hi` 2. DIVU 9 / 0 → `lo` 0xFFFFFFFF, `hi` 9. With `ALU_DIV_EN` undefined → `resultado` 0 after 1 cycle and `hi`/`lo` unchanged.
- `inicio` with AND pulsed mid-MULTU → ignored, and the MULTU result is correct. An AND 0xF0 & 0x3C issued in FIN → accepted, giving 0x30 the next cycle.
- `reset` asserted at iteration 10 of a MULTU → all outputs 0 and `cero` 1 immediately. A new MULTU 3×4 then gives `lo` 12, `hi` 0.
